device_read_responder: RTL

Read-response path of the host byte interface, clocked on clk_device. It decodes a READ command frame from the host byte stream and fetches sequential bytes from memory through a single-outstanding request port. Fetched bytes are buffered in a small FIFO and handed to the serial shift-out engine with a valid/ready handshake. It complements the write/flip command path: same frame format, opposite data direction.

---
 rtl/device_read_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/device_read_responder.sv
// Host READ-frame responder: decodes command/address bytes, prefetches memory bytes into a TX FIFO.
// Optional DEVICE_READ_UNDERRUN_CNT_EN adds an 8-bit saturating underrun counter output.
module device_read_responder #(
  parameter int         ADDRESS_WIDTH = 25,
  parameter int         FIFO_DEPTH    = 4,
  parameter logic [7:0] CMD_READ      = 8'd11
) (
  input  logic                     clk_device,
  input  logic                     reset_n,
  input  logic                     cs_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     rd_req,
  input  logic [7:0]               rd_data,
  input  logic                     rd_data_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic [1:0]               state
`ifdef DEVICE_READ_UNDERRUN_CNT_EN
  ,
  output logic [7:0]               underrun_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_next;
  logic [1:0]    byte_cnt;
  logic [23:0]   addr_shift;
  logic [31:0]   addr_full;
  logic          outstanding;
  logic          discard;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          cmd_byte;
  logic          addr_byte;
  logic          addr_last;
  logic          push;
  logic          pop;

  assign cmd_byte  = (state == S_IDLE) && rx_valid && !cs_n;
  assign addr_byte = (state == S_ADDR) && rx_valid && !cs_n;
  assign addr_last = addr_byte && (byte_cnt == 2'd3);
  assign addr_full = {addr_shift, rx_data};

  // Handshake: tx_valid means tx_data holds the FIFO head; a byte leaves on a
  // rising edge where tx_valid && tx_ready. tx_ready while empty does nothing.
  assign push = rd_data_valid && !discard && !cs_n;
  assign pop  = tx_valid && tx_ready && !cs_n;

  // FSM: state register
  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    if (cs_n) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (rx_valid) state_next = (rx_data == CMD_READ) ? S_ADDR : S_DONE;
        S_ADDR:  if (addr_last) state_next = S_FETCH;
        default: state_next = state;
      endcase
    end
  end

  // FSM: outputs decoded from registered state only
  always_comb begin
    busy   = (state == S_ADDR) || (state == S_FETCH);
    rd_req = (state == S_FETCH) && !outstanding && !discard &&
             ((fifo_count + CW'(outstanding)) < DEPTH_C);
  end

  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt   <= 2'd0;
      addr_shift <= 24'd0;
    end else if (cmd_byte) begin
      byte_cnt <= 2'd0;
    end else if (addr_byte) begin
      byte_cnt   <= byte_cnt + 2'd1;
      addr_shift <= {addr_shift[15:0], rx_data};
    end
  end

  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n)       rd_addr <= '0;
    else if (addr_last) rd_addr <= ADDRESS_WIDTH'(addr_full);
    else if (rd_req)    rd_addr <= rd_addr + ADDRESS_WIDTH'(1);
  end

  // A request still in flight when the frame ends belongs to a dead frame:
  // its response is dropped and it blocks new requests until it returns.
  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (rd_req)             outstanding <= 1'b1;
      else if (rd_data_valid) outstanding <= 1'b0;
      if (rd_data_valid)                      discard <= 1'b0;
      else if (cs_n && (outstanding || rd_req)) discard <= 1'b1;
    end
  end

  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (cs_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk_device) begin
    if (push) fifo_mem[wr_ptr] <= rd_data;
  end

  assign tx_valid = (fifo_count != '0);
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

`ifdef DEVICE_READ_UNDERRUN_CNT_EN
  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n)      underrun_cnt <= 8'd0;
    else if (cmd_byte) underrun_cnt <= 8'd0;
    else if ((state == S_FETCH) && tx_ready && (fifo_count == '0) && (underrun_cnt != 8'hFF))
      underrun_cnt <= underrun_cnt + 8'd1;
  end
`endif

endmodule
